power_meter: RTL
================

// Module: power_meter
// PURPOSE
//  Parametrised throw-power meter for the bowling game. Replaces the fixed 5-level up/down power FSM.
//  Buttons step the level up or down with saturation. A throw press freezes the level and reports it.
//  Optional auto-sweep mode bounces the level between 0 and max. Sits between the debounced
//  KEY/SW inputs and the throw/ball-physics logic and LEDR display.
// PARAMETERS
//  LEVELS     5  number of power levels (0..LEVELS-1), >=2
//  LVL_W      $clog2(LEVELS)  width of level outputs (derived, do not override)
//  SWEEP_DIV  4  clk cycles per auto-sweep step, >=1 (used only with POWER_METER_SWEEP_EN)
// PORTS
//  clk         in   1            clock
//  reset       in   1            synchronous, active-low reset
//  up          in   1            level-sensitive button; rising edge = +1
//  down        in   1            level-sensitive button; rising edge = -1
//  throw       in   1            rising edge = capture level and lock
//  clear       in   1            rising edge = unlock, return to ADJUST
//  mode        in   1            1 = auto-sweep (only with POWER_METER_SWEEP_EN)
//  lvl         out  LVL_W        current power level
//  lvl_onehot  out  LEVELS-1     bit i = (lvl == i+1); all zero at level 0 (drives LEDR)
//  locked      out  1            1 while in LOCKED
//  throw_lvl   out  LVL_W        level captured at last throw; holds until next throw or reset
//  throw_vld   out  1            one-cycle pulse on capture
// BEHAVIOUR
//  Reset (reset==0 at posedge): lvl=0, state=ADJUST, locked=0, throw_lvl=0, throw_vld=0,
//   sweep counter=0, sweep dir=up, edge history regs=1 (a button held through reset is not an edge).
//  Edge = input high at this posedge and low at previous posedge. Its effect is visible after the same
//   posedge (1-cycle latency from the input being sampled).
//  FSM states: ADJUST, LOCKED.
//  ADJUST: up edge -> lvl+1, saturating at LEVELS-1. down edge -> lvl-1, saturating at 0.
//   up and down edges in the same cycle -> lvl unchanged.
//   throw edge -> throw_lvl=lvl (pre-update value), throw_vld=1 for one cycle, ->LOCKED.
//   throw takes priority: up/down edges in the same cycle are dropped.
//   clear is ignored in ADJUST.
//  LOCKED: lvl frozen. up/down/throw/mode ignored. locked=1.
//   clear edge -> ADJUST; lvl keeps its value (no auto-zero).
//  lvl_onehot and locked decode combinationally from registers.
//  Reset mid-lock or mid-sweep returns everything to reset values on that edge.
//  Edge history regs update every cycle in both states, so a held button never re-fires.
// CONFIGURATION
//  POWER_METER_SWEEP_EN defined: in ADJUST with mode=1, up/down are ignored.
//   The counter counts 0..SWEEP_DIV-1; on wrap, lvl steps in dir. dir flips at LEVELS-1 and at 0,
//   giving a ping-pong pattern 0,1,..,max,max-1,..,0,1...
//   Counter and dir are cleared on the mode 0->1 transition, so the first step comes SWEEP_DIV cycles later.
//   throw freezes the level as in normal mode. The counter is held in LOCKED.
//  POWER_METER_SWEEP_EN undefined: the mode port exists but is ignored.
//   The sweep counter/dir logic is not built, and SWEEP_DIV is unused.
// STRUCTURE
//  Package power_pkg:
//   - state typedef (ST_ADJUST, ST_LOCKED)
//   - level-width helper function
//   - default LEVELS constant shared with display/physics blocks
//  Sub-module rise_edge (1-bit registered rising-edge detector, reset value 1), instantiated for
//   up, down, throw, clear and mode.
// TESTING
//  1. Reset, 6 up edges with LEVELS=5 -> lvl 1,2,3,4,4,4; lvl_onehot 0001,0010,0100,1000,1000,1000.
//  2. From lvl=0, down edge -> lvl=0. Then up+down rising together -> lvl unchanged.
//  3. lvl=3, throw edge -> throw_vld=1 for exactly one cycle, throw_lvl=3, locked=1.
//     Next up edges leave lvl=3. Clear edge -> locked=0, lvl=3.
//  4. Hold up high across reset release -> no increment. Hold up 10 cycles -> exactly one increment.
//  5. Reset during LOCKED with lvl=4 -> lvl=0, locked=0, throw_lvl=0 after that posedge.
//  6. SWEEP_EN, SWEEP_DIV=2, LEVELS=3, mode=1 -> lvl 0,0,1,1,2,2,1,1,0,0,1 every cycle.
//     Throw -> frozen at the current value.

Source files
------------

// File: rtl/power_pkg.sv
// Shared definitions for the throw-power meter and the blocks around it
// (display and ball-physics logic use DEFAULT_LEVELS too).
//   state_t         : meter FSM state (ST_ADJUST, ST_LOCKED)
//   DEFAULT_LEVELS  : default number of power levels
//   lvl_width()     : bits needed to hold 0..n-1, never less than 1
package power_pkg;

  typedef enum logic {
    ST_ADJUST = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int DEFAULT_LEVELS = 5;

  // Width of a counter/level that spans 0..n-1. Clamped to 1 so that
  // n==1 or n==2 still yield a legal vector width.
  function automatic int lvl_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/power_meter_rise_edge.sv
// rise_edge: registered rising-edge detector for one button.
//   clk   in  clock
//   reset in  synchronous, active-low reset
//   d     in  level-sensitive input
//   rise  out high while d is 1 now and was 0 at the previous posedge
// The history flop resets to 1, so a button already held when reset is
// released is not treated as a fresh press.
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/power_meter.sv
// power_meter: throw-power meter for the bowling game.
// Buttons step the level up/down with saturation; a throw press captures
// and freezes the level until clear is pressed.
// Optional auto-sweep (build with POWER_METER_SWEEP_EN defined): with
// mode=1 in ADJUST the level ping-pongs 0..LEVELS-1 every SWEEP_DIV cycles.
// Ports:
//   clk, reset (sync, active-low)
//   up, down, throw, clear, mode : debounced level inputs, acted on at rising edges
//   lvl        : current level
//   lvl_onehot : bit i = (lvl == i+1), zero at level 0
//   locked     : 1 while in LOCKED
//   throw_lvl  : level captured at last throw
//   throw_vld  : one-cycle pulse on capture
module power_meter
  import power_pkg::*;
#(
  parameter int LEVELS    = DEFAULT_LEVELS,
  parameter int LVL_W     = lvl_width(LEVELS),
  parameter int SWEEP_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             throw,
  input  logic             clear,
  input  logic             mode,
  output logic [LVL_W-1:0] lvl,
  output logic [LEVELS-2:0] lvl_onehot,
  output logic             locked,
  output logic [LVL_W-1:0] throw_lvl,
  output logic             throw_vld
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LEVELS - 1);

  logic up_rise, down_rise, throw_rise, clear_rise;

  rise_edge u_up_edge    (.clk(clk), .reset(reset), .d(up),    .rise(up_rise));
  rise_edge u_down_edge  (.clk(clk), .reset(reset), .d(down),  .rise(down_rise));
  rise_edge u_throw_edge (.clk(clk), .reset(reset), .d(throw), .rise(throw_rise));
  rise_edge u_clear_edge (.clk(clk), .reset(reset), .d(clear), .rise(clear_rise));

  state_t           state_q, state_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [LVL_W-1:0] throw_lvl_q, throw_lvl_d;
  logic             throw_vld_q, throw_vld_d;

  // Manual stepping; equal-and-opposite edges cancel.
  logic [LVL_W-1:0] manual_lvl;
  always_comb begin
    manual_lvl = lvl_q;
    if (up_rise && !down_rise && lvl_q != LVL_MAX) begin
      manual_lvl = lvl_q + LVL_W'(1);
    end else if (down_rise && !up_rise && lvl_q != '0) begin
      manual_lvl = lvl_q - LVL_W'(1);
    end
  end

`ifdef POWER_METER_SWEEP_EN
  localparam int CNT_W = lvl_width(SWEEP_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWEEP_DIV - 1);

  logic             mode_rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_up_q, dir_up_d;
  logic [LVL_W-1:0] sweep_lvl;

  rise_edge u_mode_edge (.clk(clk), .reset(reset), .d(mode), .rise(mode_rise));

  // Sweep datapath, only advanced in ADJUST with mode high and no throw.
  always_comb begin
    cnt_d     = cnt_q;
    dir_up_d  = dir_up_q;
    sweep_lvl = lvl_q;
    if (state_q == ST_ADJUST && mode && !throw_rise) begin
      if (mode_rise) begin
        // Restart so the first step lands a full SWEEP_DIV cycles later.
        cnt_d    = '0;
        dir_up_d = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        sweep_lvl = dir_up_q ? lvl_q + LVL_W'(1) : lvl_q - LVL_W'(1);
        // Turn around on reaching either end.
        if (sweep_lvl == LVL_MAX) begin
          dir_up_d = 1'b0;
        end else if (sweep_lvl == '0) begin
          dir_up_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      dir_up_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
    end
  end

  logic sweep_on;
  assign sweep_on = mode;
`else
  logic             sweep_on;
  logic [LVL_W-1:0] sweep_lvl;
  logic             unused_cfg;
  assign sweep_on   = 1'b0;
  assign sweep_lvl  = lvl_q;
  assign unused_cfg = mode ^ (SWEEP_DIV > 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_ADJUST;
      lvl_q       <= '0;
      throw_lvl_q <= '0;
      throw_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      throw_lvl_q <= throw_lvl_d;
      throw_vld_q <= throw_vld_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ADJUST: if (throw_rise) state_d = ST_LOCKED;
      ST_LOCKED: if (clear_rise) state_d = ST_ADJUST;
      default:   state_d = ST_ADJUST;
    endcase
  end

  // Level and capture datapath; throw wins over any step in the same cycle.
  always_comb begin
    lvl_d       = lvl_q;
    throw_lvl_d = throw_lvl_q;
    throw_vld_d = 1'b0;
    if (state_q == ST_ADJUST) begin
      if (throw_rise) begin
        throw_lvl_d = lvl_q;
        throw_vld_d = 1'b1;
      end else if (sweep_on) begin
        lvl_d = sweep_lvl;
      end else begin
        lvl_d = manual_lvl;
      end
    end
  end

  // Output decode
  always_comb begin
    locked    = (state_q == ST_LOCKED);
    lvl       = lvl_q;
    throw_lvl = throw_lvl_q;
    throw_vld = throw_vld_q;
  end

  for (genvar gi = 0; gi < LEVELS - 1; gi++) begin : g_onehot
    assign lvl_onehot[gi] = (lvl_q == LVL_W'(gi + 1));
  end

endmodule
